// File: rtl/bus_timing_sequencer.sv
// Fixed 16-clock bus cycle sequencer: SPI slot in counts 0-7, 6502 slot in counts 8-15.
// Every output is registered and is computed one clock ahead from the next count value.
module bus_timing_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_req,
    input  logic [16:0] spi_addr,
    input  logic        spi_we,
    input  logic [7:0]  spi_wdata,
    output logic        spi_ack,
    output logic [7:0]  spi_rdata,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        cpu_phi2,
    output logic [16:0] bus_addr,
    input  logic        ram_enable,
    input  logic        is_readonly,
    input  logic        io_enable,
    input  logic [7:0]  ram_data,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        io_strobe
);

    logic [3:0]  count_r;
    logic        armed_r;
    logic        grant_r;
    logic        spi_we_r;
    logic        spi_en_r;
    logic        cpu_rw_r;
    logic        cpu_en_r;
    logic        cpu_ro_r;
    logic        cpu_io_r;
    logic [16:0] bus_addr_r;
    logic [7:0]  data_out_r;
    logic [7:0]  spi_rdata_r;
    logic        spi_ack_r;
    logic        cpu_phi2_r;
    logic        data_oe_r;
    logic        ram_oe_n_r;
    logic        ram_we_n_r;
    logic        io_strobe_r;

    logic [3:0]  count_nxt_s;
    logic        spi_en_s;
    logic        cpu_en_s;
    logic        cpu_ro_s;
    logic        cpu_io_s;
    logic        spi_win_s;
    logic        cpu_rd_win_s;
    logic        cpu_wr_win_s;
    logic        late_win_s;
    logic        spi_rd_s;
    logic        spi_wr_s;
    logic        cpu_rd_s;
    logic        cpu_wr_s;
    logic        ram_oe_n_s;
    logic        ram_we_n_s;
    logic        data_oe_s;
    logic        spi_ack_s;
    logic        cpu_phi2_s;
    logic        io_strobe_s;

    // Next-cycle strobe decode from the upcoming count and the latched slot state
    always_comb begin
        count_nxt_s = count_r + 4'd1;

        // Decoder outputs are live only on their sampling clock; otherwise use the latched copy.
        if (count_r == 4'd2) begin
            spi_en_s = ram_enable;
        end else begin
            spi_en_s = spi_en_r;
        end
        if (count_r == 4'd10) begin
            cpu_en_s = ram_enable;
            cpu_ro_s = is_readonly;
            cpu_io_s = io_enable;
        end else begin
            cpu_en_s = cpu_en_r;
            cpu_ro_s = cpu_ro_r;
            cpu_io_s = cpu_io_r;
        end

        spi_win_s    = (count_nxt_s >= 4'd3)  && (count_nxt_s <= 4'd5);
        cpu_rd_win_s = (count_nxt_s >= 4'd11);
        cpu_wr_win_s = (count_nxt_s == 4'd13) || (count_nxt_s == 4'd14);
        late_win_s   = (count_nxt_s >= 4'd12);

        // SPI writes ignore is_readonly so ROM images can be loaded from the host.
        spi_rd_s = grant_r & ~spi_we_r & spi_en_s & spi_win_s;
        spi_wr_s = grant_r &  spi_we_r & spi_en_s & spi_win_s;
        cpu_rd_s =  cpu_rw_r & cpu_en_s & cpu_rd_win_s;
        cpu_wr_s = ~cpu_rw_r & cpu_en_s & ~cpu_ro_s & cpu_wr_win_s;

        ram_oe_n_s = ~(spi_rd_s | cpu_rd_s);
        ram_we_n_s = ~(spi_wr_s | cpu_wr_s);
        // data_oe opens at count 2, before the decoder answer exists, so it follows the grant alone.
        data_oe_s   = grant_r & spi_we_r & (count_nxt_s >= 4'd2) && (count_nxt_s <= 4'd6);
        spi_ack_s   = grant_r & (count_nxt_s == 4'd6);
        cpu_phi2_s  = late_win_s;
        io_strobe_s = cpu_io_s & late_win_s;
    end

    // Cycle counter, slot latches and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r     <= 4'd0;
            armed_r     <= 1'b0;
            grant_r     <= 1'b0;
            spi_we_r    <= 1'b0;
            spi_en_r    <= 1'b0;
            cpu_rw_r    <= 1'b1;
            cpu_en_r    <= 1'b0;
            cpu_ro_r    <= 1'b0;
            cpu_io_r    <= 1'b0;
            bus_addr_r  <= 17'd0;
            data_out_r  <= 8'd0;
            spi_rdata_r <= 8'd0;
            spi_ack_r   <= 1'b0;
            cpu_phi2_r  <= 1'b0;
            data_oe_r   <= 1'b0;
            ram_oe_n_r  <= 1'b1;
            ram_we_n_r  <= 1'b1;
            io_strobe_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            // The count 0 left by reset is not a sample point; the first grant comes a full cycle later.
            armed_r <= 1'b1;

            if (count_r == 4'd0) begin
                grant_r <= spi_req & armed_r;
                if (spi_req && armed_r) begin
                    spi_we_r   <= spi_we;
                    bus_addr_r <= spi_addr;
                    if (spi_we) begin
                        data_out_r <= spi_wdata;
                    end
                end
            end

            if (count_r == 4'd2) begin
                spi_en_r <= ram_enable;
            end

            if ((count_r == 4'd5) && grant_r && !spi_we_r) begin
                spi_rdata_r <= spi_en_r ? ram_data : 8'hFF;
            end

            if (count_r == 4'd8) begin
                bus_addr_r <= {1'b0, cpu_addr};
                cpu_rw_r   <= cpu_rw;
            end

            if (count_r == 4'd10) begin
                cpu_en_r <= ram_enable;
                cpu_ro_r <= is_readonly;
                cpu_io_r <= io_enable;
            end

            spi_ack_r   <= spi_ack_s;
            cpu_phi2_r  <= cpu_phi2_s;
            data_oe_r   <= data_oe_s;
            ram_oe_n_r  <= ram_oe_n_s;
            ram_we_n_r  <= ram_we_n_s;
            io_strobe_r <= io_strobe_s;
        end
    end

    assign spi_ack   = spi_ack_r;
    assign spi_rdata = spi_rdata_r;
    assign cpu_phi2  = cpu_phi2_r;
    assign bus_addr  = bus_addr_r;
    assign data_out  = data_out_r;
    assign data_oe   = data_oe_r;
    assign ram_oe_n  = ram_oe_n_r;
    assign ram_we_n  = ram_we_n_r;
    assign io_strobe = io_strobe_r;

endmodule

// File: tb/tb_bus_timing_sequencer.sv
// Directed bench for bus_timing_sequencer: walks whole bus cycles and checks every
// registered output at each count against hand-derived slot windows.
module tb_bus_timing_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_req;
    logic [16:0] spi_addr;
    logic        spi_we;
    logic [7:0]  spi_wdata;
    logic        spi_ack;
    logic [7:0]  spi_rdata;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_phi2;
    logic [16:0] bus_addr;
    logic        ram_enable;
    logic        is_readonly;
    logic        io_enable;
    logic [7:0]  ram_data;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        io_strobe;

    logic [3:0]  tb_cnt;
    logic [16:0] last_addr;
    logic [7:0]  exp_rdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    bus_timing_sequencer dut (
        .clk(clk), .reset(reset),
        .spi_req(spi_req), .spi_addr(spi_addr), .spi_we(spi_we), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_phi2(cpu_phi2), .bus_addr(bus_addr),
        .ram_enable(ram_enable), .is_readonly(is_readonly), .io_enable(io_enable),
        .ram_data(ram_data), .data_out(data_out), .data_oe(data_oe),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .io_strobe(io_strobe)
    );

    always #5 clk = ~clk;

    // Reference count: cleared by reset, advances on every rising edge
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 4'd0;
        else       tb_cnt <= tb_cnt + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (count %0d): got %h, expected %h", tag, tb_cnt, got, exp);
        end
    endtask

    // Runs one bus cycle starting at the count-0 negedge; ends on the next count-0 negedge.
    task automatic bus_cycle(input bit spi_g, input bit spi_w, input logic [16:0] spi_a,
                             input logic [7:0] wd, input logic [7:0] rd_in, input bit hold,
                             input logic [15:0] cpu_a, input bit cpu_rd,
                             input bit ram_en, input bit ro, input bit io);
        logic [16:0] exp_addr;
        bit exp_oe_low, exp_we_low, exp_doe, exp_ack, exp_phi2, exp_io;
        spi_req = spi_g; spi_addr = spi_a; spi_we = spi_w; spi_wdata = wd; ram_data = rd_in;
        cpu_addr = cpu_a; cpu_rw = cpu_rd; ram_enable = ram_en; is_readonly = ro; io_enable = io;
        for (int k = 1; k <= 16; k++) begin
            int c;
            @(negedge clk);
            c = k % 16;
            exp_addr   = (c >= 1 && c <= 8) ? (spi_g ? spi_a : last_addr) : {1'b0, cpu_a};
            exp_oe_low = (spi_g && !spi_w && ram_en && c >= 3 && c <= 5) ||
                         (cpu_rd && ram_en && c >= 11);
            exp_we_low = (spi_g && spi_w && ram_en && c >= 3 && c <= 5) ||
                         (!cpu_rd && ram_en && !ro && (c == 13 || c == 14));
            exp_doe    = spi_g && spi_w && c >= 2 && c <= 6;
            exp_ack    = spi_g && c == 6;
            exp_phi2   = c >= 12;
            exp_io     = io && c >= 12;
            check("bus_addr",  bus_addr,  exp_addr);
            check("ram_oe_n",  ram_oe_n,  !exp_oe_low);
            check("ram_we_n",  ram_we_n,  !exp_we_low);
            check("data_oe",   data_oe,   exp_doe);
            check("spi_ack",   spi_ack,   exp_ack);
            check("cpu_phi2",  cpu_phi2,  exp_phi2);
            check("io_strobe", io_strobe, exp_io);
            if (exp_doe) check("data_out", data_out, wd);
            if (c == 6 && spi_g && !spi_w) begin
                exp_rdata = ram_en ? rd_in : 8'hFF;
                check("spi_rdata", spi_rdata, exp_rdata);
            end
            if (c == 0) check("spi_rdata_hold", spi_rdata, exp_rdata);
            if (c == 6 && spi_g && !hold) spi_req = 1'b0;
        end
        last_addr = {1'b0, cpu_a};
    endtask

    initial begin
        bit seen;
        int waited;
        reset = 1'b1; spi_req = 1'b0; spi_addr = 17'd0; spi_we = 1'b0; spi_wdata = 8'd0;
        cpu_addr = 16'd0; cpu_rw = 1'b1; ram_enable = 1'b0; is_readonly = 1'b0;
        io_enable = 1'b0; ram_data = 8'd0;
        last_addr = 17'd0; exp_rdata = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_phi2", cpu_phi2, 1'b0);
        check("rst_oe_n", ram_oe_n, 1'b1);
        check("rst_we_n", ram_we_n, 1'b1);
        check("rst_doe", data_oe, 1'b0);
        check("rst_io", io_strobe, 1'b0);
        check("rst_ack", spi_ack, 1'b0);
        check("rst_addr", bus_addr, 17'd0);
        check("rst_dout", data_out, 8'd0);
        check("rst_rdata", spi_rdata, 8'd0);
        reset = 1'b0;

        // spi_g spi_w spi_a      wd     rd_in  hold  cpu_a     rd    ram_en ro    io
        bus_cycle(1'b0, 1'b0, 17'h00000, 8'h00, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 17'h00000, 8'h00, 8'h00, 1'b0, 16'hF000, 1'b0, 1'b1, 1'b1, 1'b0);
        bus_cycle(1'b0, 1'b0, 17'h00000, 8'h00, 8'h00, 1'b0, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b1, 17'h0F000, 8'hA5, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
        bus_cycle(1'b1, 1'b0, 17'h10010, 8'h00, 8'h3C, 1'b1, 16'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 17'h10011, 8'h00, 8'hC3, 1'b0, 16'h2001, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 17'h00000, 8'h00, 8'h00, 1'b0, 16'hE810, 1'b1, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, 1'b0, 17'h1ABCD, 8'h00, 8'h77, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an SPI write, then the held request must be regranted.
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 17'h00200; spi_wdata = 8'h5A;
        ram_enable = 1'b1; is_readonly = 1'b0; cpu_rw = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_we_n", ram_we_n, 1'b0);
        check("pre_rst_doe", data_oe, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_we_n", ram_we_n, 1'b1);
        check("mid_rst_doe", data_oe, 1'b0);
        check("mid_rst_ack", spi_ack, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_hold_ack", spi_ack, 1'b0);
        reset = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (spi_ack) seen = 1'b1;
        end
        check("regrant_ack", seen, 1'b1);
        check("regrant_cnt", tb_cnt, 4'd6);
        check("regrant_dout", data_out, 8'h5A);
        check("regrant_doe", data_oe, 1'b1);
        check("regrant_addr", bus_addr, 17'h00200);
        spi_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
